// File: rtl/stream_demux.sv
// Routes each input beat to one of LENGTH single-entry output slots, with 1-cycle accept-to-valid latency.
// in_ready follows the addressed slot: high if it is empty or draining now; out-of-range beats are always taken and dropped.
module stream_demux #(
    parameter  int DATA_WIDTH = 32,
    parameter  int LENGTH     = 9,
    localparam int DEST_WIDTH = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [LENGTH],
    output logic [LENGTH-1:0]     out_valid,
    input  logic [LENGTH-1:0]     out_ready,
    output logic [15:0]           drop_count,
    output logic                  out_error
);

    logic [LENGTH-1:0]     r_slot_valid;
    logic [DATA_WIDTH-1:0] r_slot_data [LENGTH];
    logic [15:0]           r_drop_count;
    logic                  r_out_error;

    logic              w_in_range;
    logic              w_slot_rdy;
    logic              w_accept;
    logic              w_drop;
    logic [LENGTH-1:0] w_load;

    assign w_in_range = (32'(in_dest) < 32'(LENGTH));
    // Index is only meaningful when in range; the mux below masks the other case.
    assign w_slot_rdy = !r_slot_valid[in_dest] || out_ready[in_dest];
    assign in_ready   = w_in_range ? w_slot_rdy : 1'b1;
    assign w_accept   = in_valid && in_ready;
    assign w_drop     = w_accept && !w_in_range;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < LENGTH; i++) begin
            w_load[i] = w_accept && w_in_range && (in_dest == DEST_WIDTH'(i));
        end
    end

    // A refill takes priority over a drain so a slot streams with no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_valid <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                if (w_load[i]) begin
                    r_slot_valid[i] <= 1'b1;
                    r_slot_data[i]  <= in_data;
                end else if (out_ready[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
            r_out_error  <= 1'b0;
        end else begin
            r_out_error <= w_drop;
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign out_valid  = r_slot_valid;
    assign out_data   = r_slot_data;
    assign drop_count = r_drop_count;
    assign out_error  = r_out_error;

endmodule

// File: tb/tb_stream_demux.sv
// Directed and random stimulus checked each cycle against a per-destination queue model.
module tb_stream_demux;

    localparam int DW  = 32;
    localparam int LEN = 9;
    localparam int DSW = $clog2(LEN);
    localparam logic [LEN-1:0] ALL = '1;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   in_data;
    logic [DSW-1:0]  in_dest;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data [LEN];
    logic [LEN-1:0]  out_valid;
    logic [LEN-1:0]  out_ready;
    logic [15:0]     drop_count;
    logic            out_error;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: each destination is a queue of beats awaiting delivery.
    logic [DW-1:0] q [LEN][$];
    int            exp_drops;
    bit            exp_err;

    stream_demux #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count),
        .out_error  (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LEN; i++) q[i].delete();
        exp_drops = 0;
        exp_err   = 1'b0;
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic cycle(input bit v, input logic [DSW-1:0] d,
                         input logic [DW-1:0] dat, input logic [LEN-1:0] ordy);
        bit             exp_rdy;
        bit             in_rng;
        logic [LEN-1:0] exp_vld;
        @(negedge clk);
        in_valid  = v;
        in_dest   = d;
        in_data   = dat;
        out_ready = ordy;
        #1;
        in_rng  = v && (int'(d) < LEN);
        exp_rdy = 1'b1;
        if (in_rng) exp_rdy = (q[d].size() == 0) || ordy[d];
        if (v) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < LEN; i++) exp_vld[i] = (q[i].size() != 0);
        chk("out_valid", 64'(out_valid), 64'(exp_vld));
        for (int i = 0; i < LEN; i++) begin
            if (q[i].size() != 0) chk($sformatf("out_data%0d", i), 64'(out_data[i]), 64'(q[i][0]));
        end
        chk("drop_count", 64'(drop_count), 64'(exp_drops));
        chk("out_error", 64'(out_error), 64'(exp_err));
        for (int i = 0; i < LEN; i++) begin
            if (ordy[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        exp_err = 1'b0;
        if (v && exp_rdy) begin
            if (in_rng) q[d].push_back(dat);
            else begin
                if (exp_drops < 16'hFFFF) exp_drops++;
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_out_error", 64'(out_error), 64'd0);
        model_clear();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [DW-1:0]  val;
        logic [LEN-1:0] stall3;
        logic [LEN-1:0] rnd_rdy;
        bit             rv;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_dest   = '0;
        in_data   = '0;
        out_ready = '0;
        model_clear();
        #12;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_drop_count", 64'(drop_count), 64'd0);
        chk("init_out_error", 64'(out_error), 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Every destination in turn with all consumers ready.
        for (int d = 0; d < LEN; d++) begin
            val = 32'h11110000 * (d + 1);
            cycle(1'b1, DSW'(d), val, ALL);
        end
        cycle(1'b0, '0, '0, ALL);
        cycle(1'b0, '0, '0, ALL);

        // Stall destination 3 with a second beat waiting behind the first.
        stall3 = ALL;
        stall3[3] = 1'b0;
        cycle(1'b1, 4'd3, 32'hA0A0_0001, stall3);
        cycle(1'b1, 4'd3, 32'hB0B0_0002, stall3);
        chk("stall_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 4'd3, 32'hB0B0_0002, stall3);
        chk("stall_hold3", 64'(out_data[3]), 64'hA0A0_0001);
        cycle(1'b1, 4'd3, 32'hB0B0_0002, ALL);
        chk("release_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, '0, '0, stall3);
        chk("release_data3", 64'(out_data[3]), 64'hB0B0_0002);

        // Destination 4 keeps flowing while 3 stays blocked.
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) cycle(1'b1, 4'd3, 32'hC0C0_0000 + k, stall3);
            else            cycle(1'b1, 4'd4, 32'hD0D0_0000 + k, stall3);
        end
        chk("interleave_hold3", 64'(out_data[3]), 64'hB0B0_0002);
        cycle(1'b0, '0, '0, ALL);
        cycle(1'b0, '0, '0, ALL);

        // Random traffic, including out-of-range and junk when idle.
        for (int k = 0; k < 3000; k++) begin
            rv      = ($urandom_range(0, 9) < 7);
            rnd_rdy = LEN'($urandom) | LEN'($urandom);
            if (rv) cycle(1'b1, DSW'($urandom_range(0, 15)), $urandom, rnd_rdy);
            else    cycle(1'b0, 'x, 'x, rnd_rdy);
        end

        // Reset with held beats in slots 0 and 5.
        cycle(1'b1, 4'd0, 32'h0000_AAAA, '0);
        cycle(1'b1, 4'd5, 32'h0005_AAAA, '0);
        cycle(1'b1, 4'd12, 32'hDEAD_BEEF, '0);
        cycle(1'b0, '0, '0, '0);
        async_reset();
        cycle(1'b1, 4'd5, 32'h0005_5555, ALL);
        cycle(1'b0, '0, '0, ALL);
        chk("post_rst_data5", 64'(out_data[5]), 64'h0005_5555);

        // Back-to-back drops, then saturation.
        cycle(1'b1, 4'd9, 32'h1, ALL);
        cycle(1'b1, 4'd10, 32'h2, ALL);
        cycle(1'b1, 4'd15, 32'h3, ALL);
        cycle(1'b0, '0, '0, ALL);
        chk("drop3_count", 64'(drop_count), 64'd3);
        for (int k = 0; k < 70000; k++) cycle(1'b1, 4'd15, '0, ALL);
        cycle(1'b0, '0, '0, ALL);
        chk("drop_saturate", 64'(drop_count), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
